// File: rtl/rv32_hazard_ctrl.sv
// RV32 five-stage pipeline hazard controller: operand forwarding select, load-use stall,
// and redirect flush sequencing, with saturating stall/flush performance counters.
module rv32_hazard_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1_reg,
  input  logic [4:0]       id_rs2_reg,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic             id_valid,
  input  logic             ex_wb_enable,
  input  logic [4:0]       ex_wb_reg,
  input  logic             ex_wb_from_mem,
  input  logic             mem_wb_enable,
  input  logic [4:0]       mem_wb_reg,
  input  logic             wb_wb_enable,
  input  logic [4:0]       wb_wb_reg,
  input  logic             ex_redirect,
  output logic             stall_if_id,
  output logic             bubble_ex,
  output logic             flush,
  output logic [1:0]       fwd_rs1_sel,
  output logic [1:0]       fwd_rs2_sel,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StStall   = 2'd1,
    StFlush   = 2'd2,
    StIllegal = 2'd3
  } state_e;

  localparam logic [2:0] FlushReload   = 3'(FLUSH_CYCLES - 1);
  // A single-cycle flush is fully covered by the redirect cycle itself.
  localparam state_e     RedirectState = (FLUSH_CYCLES > 1) ? StFlush : StRun;

  state_e           state_q, state_d;
  logic [2:0]       fcnt_q, fcnt_d;
  logic [CNT_W-1:0] stall_count_q, flush_count_q;
  logic [2:0]       hit1, hit2;
  logic             load_use;
  logic             stall_raw, bubble_raw, flush_raw;

  // hit bits: [0]=EX, [1]=MEM, [2]=WB
  always_comb begin
    hit1[0] = ex_wb_enable  && (ex_wb_reg  == id_rs1_reg);
    hit1[1] = mem_wb_enable && (mem_wb_reg == id_rs1_reg);
    hit1[2] = wb_wb_enable  && (wb_wb_reg  == id_rs1_reg);
    hit2[0] = ex_wb_enable  && (ex_wb_reg  == id_rs2_reg);
    hit2[1] = mem_wb_enable && (mem_wb_reg == id_rs2_reg);
    hit2[2] = wb_wb_enable  && (wb_wb_reg  == id_rs2_reg);
    if (!id_rs1_used || (id_rs1_reg == 5'd0)) hit1 = 3'b000;
    if (!id_rs2_used || (id_rs2_reg == 5'd0)) hit2 = 3'b000;
    fwd_rs1_sel = hit1[0] ? 2'd1 : hit1[1] ? 2'd2 : hit1[2] ? 2'd3 : 2'd0;
    fwd_rs2_sel = hit2[0] ? 2'd1 : hit2[1] ? 2'd2 : hit2[2] ? 2'd3 : 2'd0;
    load_use    = id_valid && ex_wb_from_mem && (hit1[0] || hit2[0]);
  end

  always_comb begin
    state_d    = state_q;
    fcnt_d     = fcnt_q;
    stall_raw  = 1'b0;
    bubble_raw = 1'b0;
    flush_raw  = 1'b0;
    case (state_q)
      StRun, StStall: begin
        if (ex_redirect) begin
          flush_raw  = 1'b1;
          bubble_raw = 1'b1;
          fcnt_d     = FlushReload;
          state_d    = RedirectState;
        end else if ((state_q == StRun) && load_use) begin
          stall_raw  = 1'b1;
          bubble_raw = 1'b1;
          state_d    = StStall;
        end else begin
          state_d = StRun;
        end
      end
      StFlush: begin
        flush_raw  = 1'b1;
        bubble_raw = 1'b1;
        if (ex_redirect) begin
          fcnt_d  = FlushReload;
          state_d = RedirectState;
        end else if (fcnt_q <= 3'd1) begin
          fcnt_d  = 3'd0;
          state_d = StRun;
        end else begin
          fcnt_d = fcnt_q - 3'd1;
        end
      end
      default: begin
        fcnt_d  = 3'd0;
        state_d = StRun;
      end
    endcase
  end

  assign stall_if_id = stall_raw  && !reset;
  assign bubble_ex   = bubble_raw && !reset;
  assign flush       = flush_raw  && !reset;
  assign state       = state_q;
  assign stall_count = stall_count_q;
  assign flush_count = flush_count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StRun;
      fcnt_q        <= 3'd0;
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      if (stall_if_id && (stall_count_q != '1)) stall_count_q <= stall_count_q + CNT_W'(1);
      if (flush && (flush_count_q != '1)) flush_count_q <= flush_count_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_rv32_hazard_ctrl.sv
// Scoreboard bench for rv32_hazard_ctrl: directed hazard scenarios plus random traffic,
// checked against a cycle-level behavioural model of the hazard rules.
module tb_rv32_hazard_ctrl;
  localparam int unsigned FC   = 2;
  localparam int unsigned CW   = 4;
  localparam int          CMAX = (1 << CW) - 1;

  logic          clk;
  logic          reset;
  logic [4:0]    id_rs1_reg, id_rs2_reg;
  logic          id_rs1_used, id_rs2_used, id_valid;
  logic          ex_wb_enable, ex_wb_from_mem;
  logic [4:0]    ex_wb_reg;
  logic          mem_wb_enable, wb_wb_enable;
  logic [4:0]    mem_wb_reg, wb_wb_reg;
  logic          ex_redirect;
  logic          stall_if_id, bubble_ex, flush;
  logic [1:0]    fwd_rs1_sel, fwd_rs2_sel, state;
  logic [CW-1:0] stall_count, flush_count;

  rv32_hazard_ctrl #(
    .FLUSH_CYCLES(FC),
    .CNT_W       (CW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .id_rs1_reg    (id_rs1_reg),
    .id_rs2_reg    (id_rs2_reg),
    .id_rs1_used   (id_rs1_used),
    .id_rs2_used   (id_rs2_used),
    .id_valid      (id_valid),
    .ex_wb_enable  (ex_wb_enable),
    .ex_wb_reg     (ex_wb_reg),
    .ex_wb_from_mem(ex_wb_from_mem),
    .mem_wb_enable (mem_wb_enable),
    .mem_wb_reg    (mem_wb_reg),
    .wb_wb_enable  (wb_wb_enable),
    .wb_wb_reg     (wb_wb_reg),
    .ex_redirect   (ex_redirect),
    .stall_if_id   (stall_if_id),
    .bubble_ex     (bubble_ex),
    .flush         (flush),
    .fwd_rs1_sel   (fwd_rs1_sel),
    .fwd_rs2_sel   (fwd_rs2_sel),
    .state         (state),
    .stall_count   (stall_count),
    .flush_count   (flush_count)
  );

  typedef struct {
    int f1, f2, st, scnt, fcnt;
    bit stall, bubble, fl;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  // Model: flush cycles still owed after the current one, and whether we sit in a stall slot.
  int   pending = 0;
  bit   stalled = 0;
  int   m_scnt = 0;
  int   m_fcnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int model_fwd(input logic [4:0] rs, input logic used);
    if (!used || rs == 5'd0) return 0;
    if (ex_wb_enable && ex_wb_reg == rs) return 1;
    if (mem_wb_enable && mem_wb_reg == rs) return 2;
    if (wb_wb_enable && wb_wb_reg == rs) return 3;
    return 0;
  endfunction

  task automatic issue();
    exp_t e;
    bit   lu, in_flush, fl, st;
    e.f1     = model_fwd(id_rs1_reg, id_rs1_used);
    e.f2     = model_fwd(id_rs2_reg, id_rs2_used);
    lu       = id_valid && ex_wb_from_mem && (e.f1 == 1 || e.f2 == 1);
    in_flush = pending > 0;
    fl       = ex_redirect || in_flush;
    st       = !ex_redirect && !in_flush && !stalled && lu;
    e.st     = in_flush ? 2 : (stalled ? 1 : 0);
    e.scnt   = m_scnt;
    e.fcnt   = m_fcnt;
    if (reset) begin
      e.stall = 0; e.bubble = 0; e.fl = 0;
      pending = 0; stalled = 0; m_scnt = 0; m_fcnt = 0;
    end else begin
      e.stall  = st;
      e.bubble = fl || st;
      e.fl     = fl;
      if (ex_redirect) pending = int'(FC) - 1;
      else if (pending > 0) pending--;
      stalled = st;
      if (st && m_scnt < CMAX) m_scnt++;
      if (fl && m_fcnt < CMAX) m_fcnt++;
    end
    q.push_back(e);
  endtask

  task automatic clr();
    id_rs1_reg = 0; id_rs2_reg = 0; id_rs1_used = 0; id_rs2_used = 0; id_valid = 0;
    ex_wb_enable = 0; ex_wb_reg = 0; ex_wb_from_mem = 0;
    mem_wb_enable = 0; mem_wb_reg = 0; wb_wb_enable = 0; wb_wb_reg = 0;
    ex_redirect = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every cycle the DUT presents a response, checked at the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("fwd_rs1_sel", 32'(fwd_rs1_sel), 32'(e.f1));
        chk("fwd_rs2_sel", 32'(fwd_rs2_sel), 32'(e.f2));
        chk("stall_if_id", 32'(stall_if_id), 32'(e.stall));
        chk("bubble_ex", 32'(bubble_ex), 32'(e.bubble));
        chk("flush", 32'(flush), 32'(e.fl));
        chk("state", 32'(state), 32'(e.st));
        chk("stall_count", 32'(stall_count), 32'(e.scnt));
        chk("flush_count", 32'(flush_count), 32'(e.fcnt));
      end
    end
  end

  initial begin
    clr();
    reset = 1'b1;
    @(posedge clk);
    #1;
    issue();                         // reset state
    // EX ALU result to x5 forwarded, no stall
    tick(); reset = 0; clr();
    id_valid = 1; id_rs1_reg = 5; id_rs1_used = 1;
    ex_wb_enable = 1; ex_wb_reg = 5;
    issue();
    // load-use on rs2=x7: stall, then MEM forward in STALL, then RUN
    tick(); clr();
    id_valid = 1; id_rs2_reg = 7; id_rs2_used = 1;
    ex_wb_enable = 1; ex_wb_reg = 7; ex_wb_from_mem = 1;
    issue();
    tick(); clr();
    id_valid = 1; id_rs2_reg = 7; id_rs2_used = 1;
    mem_wb_enable = 1; mem_wb_reg = 7;
    issue();
    tick(); clr(); issue();
    // EX/MEM/WB all write x3: EX wins; x0 never forwards
    tick(); clr();
    id_valid = 1; id_rs1_reg = 3; id_rs1_used = 1;
    ex_wb_enable = 1; ex_wb_reg = 3; mem_wb_enable = 1; mem_wb_reg = 3;
    wb_wb_enable = 1; wb_wb_reg = 3;
    issue();
    tick(); id_rs1_reg = 0; ex_wb_reg = 0; mem_wb_reg = 0; wb_wb_reg = 0; issue();
    // MEM and WB only
    tick(); clr(); id_valid = 1; id_rs2_reg = 9; id_rs2_used = 1;
    mem_wb_enable = 1; mem_wb_reg = 9; wb_wb_enable = 1; wb_wb_reg = 9; issue();
    tick(); mem_wb_enable = 0; issue();
    // redirect together with load-use: redirect wins
    tick(); clr();
    id_valid = 1; id_rs1_reg = 4; id_rs1_used = 1;
    ex_wb_enable = 1; ex_wb_reg = 4; ex_wb_from_mem = 1; ex_redirect = 1;
    issue();
    for (int i = 0; i < 3; i++) begin
      tick(); clr(); issue();
    end
    // redirect, then reset on the next cycle
    tick(); clr(); ex_redirect = 1; issue();
    tick(); clr(); reset = 1; issue();
    tick(); reset = 0; issue();
    tick(); issue();
    // sustained load-use to saturate stall_count
    for (int i = 0; i < 2 * ((1 << CW) + 3); i++) begin
      tick(); clr();
      id_valid = 1; id_rs1_reg = 6; id_rs1_used = 1;
      ex_wb_enable = 1; ex_wb_reg = 6; ex_wb_from_mem = 1;
      issue();
    end
    // random traffic over a small register set to provoke matches
    for (int i = 0; i < 2000; i++) begin
      tick();
      reset          = ($urandom_range(0, 39) == 0);
      id_rs1_reg     = 5'($urandom_range(0, 3));
      id_rs2_reg     = 5'($urandom_range(0, 3));
      id_rs1_used    = 1'($urandom_range(0, 1));
      id_rs2_used    = 1'($urandom_range(0, 1));
      id_valid       = ($urandom_range(0, 3) != 0);
      ex_wb_enable   = 1'($urandom_range(0, 1));
      ex_wb_reg      = 5'($urandom_range(0, 3));
      ex_wb_from_mem = 1'($urandom_range(0, 1));
      mem_wb_enable  = 1'($urandom_range(0, 1));
      mem_wb_reg     = 5'($urandom_range(0, 3));
      wb_wb_enable   = 1'($urandom_range(0, 1));
      wb_wb_reg      = 5'($urandom_range(0, 3));
      ex_redirect    = ($urandom_range(0, 7) == 0);
      issue();
    end
    tick(); clr();
    @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
